wb_regfile: RTL and testbench

Writeback stage that consumes the registered outputs of the MEX/WB pipeline register.
- Selects the writeback result: ALU value or memory load data.
- Commits the result to an 8-entry x 8-bit register file and updates the architectural carry flag.
- Provides two combinational read ports, with same-cycle write bypass, to the decode stage.
- Drives a registered forwarding bus back to the MEX stage.
- Counts retired instructions.

---
 rtl/wb_regfile.sv | 100 ++++++++++
 tb/tb_wb_regfile.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// Writeback stage: selects ALU/load result, commits it to the register file and carry flag,
// bypasses it to the decode read ports, forwards it to MEX one cycle later and counts retirements.
module wb_regfile #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int RETIRE_W = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                wb_valid,
  input  logic                wb_reg_write,
  input  logic                wb_carry_write,
  input  logic                wb_mem_read,
  input  logic [DATA_W-1:0]   wb_write_val,
  input  logic [DATA_W-1:0]   wb_data_val,
  input  logic [ADDR_W-1:0]   wb_write_addr,
  input  logic                wb_carry_out,
  input  logic [ADDR_W-1:0]   read_addr1,
  input  logic [ADDR_W-1:0]   read_addr2,
  output logic [DATA_W-1:0]   read_val1,
  output logic [DATA_W-1:0]   read_val2,
  output logic                carry_flag,
  output logic                fwd_valid,
  output logic [ADDR_W-1:0]   fwd_addr,
  output logic [DATA_W-1:0]   fwd_val,
  output logic [RETIRE_W-1:0] retire_count
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0]   regs_q [NREGS];
  logic                carry_q, carry_d;
  logic                fwd_valid_q, fwd_valid_d;
  logic [ADDR_W-1:0]   fwd_addr_q, fwd_addr_d;
  logic [DATA_W-1:0]   fwd_val_q, fwd_val_d;
  logic [RETIRE_W-1:0] retire_q, retire_d;

  logic              live, we, ce;
  logic [DATA_W-1:0] result;

  // Flushed slots carry X; only a definite 1 on a qualifier may change state.
  always_comb begin
    live   = (wb_valid === 1'b1);
    we     = live && (wb_reg_write === 1'b1);
    ce     = live && (wb_carry_write === 1'b1);
    result = (wb_mem_read === 1'b1) ? wb_data_val : wb_write_val;
  end

  always_comb begin
    read_val1 = regs_q[read_addr1];
    read_val2 = regs_q[read_addr2];
    if (we && (read_addr1 == wb_write_addr)) read_val1 = result;
    if (we && (read_addr2 == wb_write_addr)) read_val2 = result;
  end

  always_comb begin
    carry_d     = carry_q;
    fwd_valid_d = we;
    fwd_addr_d  = fwd_addr_q;
    fwd_val_d   = fwd_val_q;
    retire_d    = retire_q;
    if (ce) carry_d = (wb_carry_out === 1'b1);
    if (we) begin
      fwd_addr_d = wb_write_addr;
      fwd_val_d  = result;
    end
    if (live && (retire_q != {RETIRE_W{1'b1}})) retire_d = retire_q + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (we) begin
      regs_q[wb_write_addr] <= result;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      carry_q     <= 1'b0;
      fwd_valid_q <= 1'b0;
      fwd_addr_q  <= '0;
      fwd_val_q   <= '0;
      retire_q    <= '0;
    end else begin
      carry_q     <= carry_d;
      fwd_valid_q <= fwd_valid_d;
      fwd_addr_q  <= fwd_addr_d;
      fwd_val_q   <= fwd_val_d;
      retire_q    <= retire_d;
    end
  end

  assign carry_flag   = carry_q;
  assign fwd_valid    = fwd_valid_q;
  assign fwd_addr     = fwd_addr_q;
  assign fwd_val      = fwd_val_q;
  assign retire_count = retire_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile; a second instance with a 3-bit counter checks saturation.
module tb_wb_regfile;

  logic       clock = 1'b0;
  logic       reset;
  logic       wb_valid, wb_reg_write, wb_carry_write, wb_mem_read, wb_carry_out;
  logic [7:0] wb_write_val, wb_data_val;
  logic [2:0] wb_write_addr, read_addr1, read_addr2;

  logic [7:0]  read_val1, read_val2, fwd_val;
  logic        carry_flag, fwd_valid;
  logic [2:0]  fwd_addr;
  logic [15:0] retire_count;

  logic [7:0] s_read_val1, s_read_val2, s_fwd_val;
  logic       s_carry_flag, s_fwd_valid;
  logic [2:0] s_fwd_addr;
  logic [2:0] s_retire_count;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  wb_regfile dut (
    .clock(clock), .reset(reset), .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
    .wb_carry_write(wb_carry_write), .wb_mem_read(wb_mem_read), .wb_write_val(wb_write_val),
    .wb_data_val(wb_data_val), .wb_write_addr(wb_write_addr), .wb_carry_out(wb_carry_out),
    .read_addr1(read_addr1), .read_addr2(read_addr2), .read_val1(read_val1),
    .read_val2(read_val2), .carry_flag(carry_flag), .fwd_valid(fwd_valid),
    .fwd_addr(fwd_addr), .fwd_val(fwd_val), .retire_count(retire_count)
  );

  wb_regfile #(.RETIRE_W(3)) dut_sat (
    .clock(clock), .reset(reset), .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
    .wb_carry_write(wb_carry_write), .wb_mem_read(wb_mem_read), .wb_write_val(wb_write_val),
    .wb_data_val(wb_data_val), .wb_write_addr(wb_write_addr), .wb_carry_out(wb_carry_out),
    .read_addr1(read_addr1), .read_addr2(read_addr2), .read_val1(s_read_val1),
    .read_val2(s_read_val2), .carry_flag(s_carry_flag), .fwd_valid(s_fwd_valid),
    .fwd_addr(s_fwd_addr), .fwd_val(s_fwd_val), .retire_count(s_retire_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    wb_valid = 1'b0; wb_reg_write = 1'b0; wb_carry_write = 1'b0; wb_mem_read = 1'b0;
    wb_carry_out = 1'b0; wb_write_val = 8'h00; wb_data_val = 8'h00; wb_write_addr = 3'd0;
  endtask

  task automatic alu_write(input logic [2:0] a, input logic [7:0] v);
    wb_valid = 1'b1; wb_reg_write = 1'b1; wb_carry_write = 1'b0; wb_mem_read = 1'b0;
    wb_write_addr = a; wb_write_val = v; wb_data_val = 8'hFF;
  endtask

  initial begin
    idle();
    read_addr1 = 3'd0; read_addr2 = 3'd0;
    reset = 1'b1;
    #2;
    chk("rst_read1", {24'h0, read_val1}, 32'h00);
    chk("rst_read2", {24'h0, read_val2}, 32'h00);
    chk("rst_carry", {31'h0, carry_flag}, 32'h0);
    chk("rst_fwd_valid", {31'h0, fwd_valid}, 32'h0);
    chk("rst_retire", {16'h0, retire_count}, 32'h0);
    #10;
    reset = 1'b0;

    // ALU-path write to r3
    alu_write(3'd3, 8'h5A);
    read_addr1 = 3'd3; read_addr2 = 3'd0;
    #1;
    chk("alu_bypass1", {24'h0, read_val1}, 32'h5A);
    chk("alu_no_bypass2", {24'h0, read_val2}, 32'h00);
    edge1();
    idle();
    #1;
    chk("alu_fwd_valid", {31'h0, fwd_valid}, 32'h1);
    chk("alu_fwd_addr", {29'h0, fwd_addr}, 32'h3);
    chk("alu_fwd_val", {24'h0, fwd_val}, 32'h5A);
    chk("alu_retire", {16'h0, retire_count}, 32'h1);
    chk("alu_reg_read", {24'h0, read_val1}, 32'h5A);

    // Load path, both ports bypass r7
    alu_write(3'd7, 8'h00);
    wb_mem_read = 1'b1; wb_data_val = 8'hC3;
    read_addr1 = 3'd7; read_addr2 = 3'd7;
    #1;
    chk("load_bypass1", {24'h0, read_val1}, 32'hC3);
    chk("load_bypass2", {24'h0, read_val2}, 32'hC3);
    edge1();
    idle();
    #1;
    chk("load_reg_read1", {24'h0, read_val1}, 32'hC3);
    chk("load_reg_read2", {24'h0, read_val2}, 32'hC3);
    chk("load_fwd_val", {24'h0, fwd_val}, 32'hC3);
    chk("load_retire", {16'h0, retire_count}, 32'h2);

    // Flushed slot must not disturb r5
    alu_write(3'd5, 8'h11);
    edge1();
    wb_valid = 1'bx; wb_reg_write = 1'bx; wb_carry_write = 1'bx; wb_mem_read = 1'bx;
    wb_write_val = 8'hxx; wb_data_val = 8'hxx; wb_carry_out = 1'bx; wb_write_addr = 3'd5;
    read_addr1 = 3'd5; read_addr2 = 3'd3;
    #1;
    chk("flush_read_same_cycle", {24'h0, read_val1}, 32'h11);
    edge1();
    chk("flush_r5", {24'h0, read_val1}, 32'h11);
    chk("flush_r3", {24'h0, read_val2}, 32'h5A);
    chk("flush_carry", {31'h0, carry_flag}, 32'h0);
    chk("flush_fwd_valid", {31'h0, fwd_valid}, 32'h0);
    chk("flush_fwd_addr", {29'h0, fwd_addr}, 32'h5);
    chk("flush_fwd_val", {24'h0, fwd_val}, 32'h11);
    chk("flush_retire", {16'h0, retire_count}, 32'h3);

    // Carry update without register write, then hold
    idle();
    wb_valid = 1'b1; wb_carry_write = 1'b1; wb_carry_out = 1'b1;
    edge1();
    chk("carry_set", {31'h0, carry_flag}, 32'h1);
    chk("carry_fwd_valid", {31'h0, fwd_valid}, 32'h0);
    chk("carry_retire", {16'h0, retire_count}, 32'h4);
    wb_carry_write = 1'b0; wb_carry_out = 1'b0;
    edge1();
    chk("carry_hold", {31'h0, carry_flag}, 32'h1);
    chk("carry_hold_retire", {16'h0, retire_count}, 32'h5);

    // Back-to-back writes to r2
    alu_write(3'd2, 8'h10);
    read_addr1 = 3'd2;
    edge1();
    chk("b2b_fwd_first", {24'h0, fwd_val}, 32'h10);
    alu_write(3'd2, 8'h20);
    edge1();
    chk("b2b_fwd_second", {24'h0, fwd_val}, 32'h20);
    chk("b2b_fwd_valid", {31'h0, fwd_valid}, 32'h1);
    idle();
    #1;
    chk("b2b_reg", {24'h0, read_val1}, 32'h20);
    edge1();
    chk("b2b_fwd_drop", {31'h0, fwd_valid}, 32'h0);
    chk("b2b_retire", {16'h0, retire_count}, 32'h7);

    // Async reset between edges
    #2;
    reset = 1'b1;
    #1;
    chk("arst_read1", {24'h0, read_val1}, 32'h00);
    chk("arst_carry", {31'h0, carry_flag}, 32'h0);
    chk("arst_fwd_val", {24'h0, fwd_val}, 32'h00);
    chk("arst_fwd_addr", {29'h0, fwd_addr}, 32'h0);
    chk("arst_retire", {16'h0, retire_count}, 32'h0);
    #1;
    reset = 1'b0;
    alu_write(3'd1, 8'h77);
    edge1();
    idle();
    chk("post_rst_fwd_valid", {31'h0, fwd_valid}, 32'h1);
    chk("post_rst_fwd_val", {24'h0, fwd_val}, 32'h77);
    chk("post_rst_retire", {16'h0, retire_count}, 32'h1);

    // Saturation: 10 live slots after a fresh reset
    reset = 1'b1;
    #1;
    reset = 1'b0;
    wb_valid = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      edge1();
      if (i == 6) chk("sat_count_6", {29'h0, s_retire_count}, 32'h6);
      if (i == 7) chk("sat_count_7", {29'h0, s_retire_count}, 32'h7);
    end
    chk("sat_hold", {29'h0, s_retire_count}, 32'h7);
    chk("wide_count_10", {16'h0, retire_count}, 32'hA);
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
